axi_slave_ram: RTL and testbench

Word-addressed AXI4 slave memory that sits directly downstream of the team's AXI master bench and consumes its write and read bursts. It decodes a single address window onto an internal RAM and supports FIXED, INCR and optionally WRAP bursts with byte strobes. Out-of-window accesses complete with DECERR, so the master's error-reporting paths can be exercised. Write and read channels run independently, with one outstanding transaction per direction.

---
 rtl/axi_slave_ram_if.sv | 25 ++
 rtl/axi_slave_ram.sv | 168 ++++++++++++++++
 tb/tb_axi_slave_ram.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_ram_if.sv
// axi_slave_ram_if: AXI4 bus bundle between a master and the slave RAM
interface axi_slave_ram_if #(
  parameter int AXI_ID_WIDTH = 1,
  parameter int AXI_ADDR_WIDTH = 32
);
  logic [AXI_ID_WIDTH-1:0] awid, bid, arid, rid;
  logic [AXI_ADDR_WIDTH-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_slave_ram.sv
// axi_slave_ram: AXI4 word RAM slave with FIXED/INCR bursts, DECERR/SLVERR, WRAP under AXI_SLAVE_RAM_WRAP_EN
module axi_slave_ram #(
  parameter int AXI_ID_WIDTH = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MEM_WORDS_LOG2 = 10,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h1000_0000
) (
  input logic aclk,
  input logic areset,
  axi_slave_ram_if.slave axi
);
  localparam int A = AXI_ADDR_WIDTH;
  localparam int NB = AXI_DATA_WIDTH / 8;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  logic [AXI_DATA_WIDTH-1:0] mem [0:(1<<MEM_WORDS_LOG2)-1];
  w_state_t ws, ws_n;
  r_state_t rs, rs_n;
  logic up, aw_hs, w_hs, ar_hs, r_hs, w_lbad, w_lbad_n, aw_wok, ar_wok;
  logic [A-1:0] w_addr, r_addr, w_nxt, r_nxt;
  logic [7:0] w_len, w_cnt, r_len, r_cnt;
  logic [1:0] w_burst, r_burst, w_err, r_err, b_resp, aw_chk, ar_chk, r_nerr;
  logic [AXI_ID_WIDTH-1:0] w_id, r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;

  function automatic logic in_win(input logic [A-1:0] a);
    logic [A-1:0] off;
    off = a - BASE_ADDR;
    return a >= BASE_ADDR && (off >> (MEM_WORDS_LOG2 + 2)) == '0;
  endfunction

  function automatic logic [MEM_WORDS_LOG2-1:0] idx(input logic [A-1:0] a);
    logic [A-1:0] off;
    off = (a - BASE_ADDR) >> 2;
    return MEM_WORDS_LOG2'(off);
  endfunction

  function automatic logic [1:0] chk(input logic [2:0] s, input logic [1:0] b, input logic wok, input logic [A-1:0] a);
    if (s != 3'b010 || b == 2'b11 || (b == 2'b10 && !wok)) return SLVERR;
    return in_win(a) ? OKAY : DECERR;
  endfunction

  function automatic logic [1:0] step(input logic [1:0] e, input logic [A-1:0] a);
    return e != OKAY ? e : in_win(a) ? OKAY : DECERR;
  endfunction

`ifdef AXI_SLAVE_RAM_WRAP_EN
  function automatic logic [A-1:0] wrap(input logic [A-1:0] a, input logic [7:0] l);
    logic [A-1:0] span, bnd;
    span = ({{(A-8){1'b0}}, l} + A'(1)) << 2;
    bnd = a & ~(span - A'(1));
    return a + A'(4) == bnd + span ? bnd : a + A'(4);
  endfunction
  assign aw_wok = axi.awlen inside {8'd1, 8'd3, 8'd7, 8'd15};
  assign ar_wok = axi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15};
  assign w_nxt = w_burst == 2'b10 ? wrap(w_addr, w_len) : w_burst == 2'b00 ? w_addr : w_addr + A'(4);
  assign r_nxt = r_burst == 2'b10 ? wrap(r_addr, r_len) : r_burst == 2'b00 ? r_addr : r_addr + A'(4);
`else
  assign aw_wok = 1'b0;
  assign ar_wok = 1'b0;
  assign w_nxt = w_burst == 2'b00 ? w_addr : w_addr + A'(4);
  assign r_nxt = r_burst == 2'b00 ? r_addr : r_addr + A'(4);
`endif

  assign aw_hs = axi.awvalid && up && ws == W_IDLE;
  assign w_hs = axi.wvalid && ws == W_DATA;
  assign ar_hs = axi.arvalid && up && rs == R_IDLE;
  assign r_hs = axi.rready && rs == R_DATA;
  assign aw_chk = chk(axi.awsize, axi.awburst, aw_wok, axi.awaddr);
  assign ar_chk = chk(axi.arsize, axi.arburst, ar_wok, axi.araddr);
  assign w_lbad_n = w_lbad || (axi.wlast != (w_cnt == w_len));
  assign r_nerr = step(r_err, r_nxt);

  // state registers; up delays the address readies one edge past reset release
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      ws <= W_IDLE;
      rs <= R_IDLE;
      up <= 1'b0;
    end else begin
      ws <= ws_n;
      rs <= rs_n;
      up <= 1'b1;
    end

  // write FSM next state and handshake outputs
  always_comb begin
    ws_n = ws == W_IDLE ? (aw_hs ? W_DATA : W_IDLE) :
           ws == W_DATA ? (axi.wvalid && w_cnt == w_len ? W_RESP : W_DATA) :
           (axi.bready ? W_IDLE : W_RESP);
    axi.awready = up && ws == W_IDLE;
    axi.wready = ws == W_DATA;
    axi.bvalid = ws == W_RESP;
    axi.bid = w_id;
    axi.bresp = b_resp;
  end

  // read FSM next state and beat outputs
  always_comb begin
    rs_n = rs == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (r_hs && r_cnt == r_len ? R_IDLE : R_DATA);
    axi.arready = up && rs == R_IDLE;
    axi.rvalid = rs == R_DATA;
    axi.rlast = rs == R_DATA && r_cnt == r_len;
    axi.rid = r_id;
    axi.rresp = r_err;
    axi.rdata = r_data;
  end

  // write burst tracking: address walk, sticky beat error, wlast mismatch, final response
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      w_addr <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_burst <= '0;
      w_err <= OKAY;
      w_lbad <= 1'b0;
      w_id <= '0;
      b_resp <= OKAY;
    end else if (aw_hs) begin
      w_addr <= {axi.awaddr[A-1:2], 2'b00};
      w_len <= axi.awlen;
      w_cnt <= '0;
      w_burst <= axi.awburst;
      w_err <= aw_chk;
      w_lbad <= 1'b0;
      w_id <= axi.awid;
    end else if (w_hs) begin
      w_addr <= w_nxt;
      w_err <= step(w_err, w_nxt);
      w_cnt <= w_cnt + 8'd1;
      w_lbad <= w_lbad_n;
      if (w_cnt == w_len) b_resp <= w_err != OKAY ? w_err : w_lbad_n ? SLVERR : OKAY;
    end

  // RAM byte writes; contents survive reset
  always_ff @(posedge aclk)
    if (w_hs && w_err == OKAY)
      for (int b = 0; b < NB; b++)
        if (axi.wstrb[b]) mem[idx(w_addr)][8*b +: 8] <= axi.wdata[8*b +: 8];

  // read burst tracking; each beat's data is fetched on the edge that accepts the previous one
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_addr <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_burst <= '0;
      r_err <= OKAY;
      r_id <= '0;
      r_data <= '0;
    end else if (ar_hs) begin
      r_addr <= {axi.araddr[A-1:2], 2'b00};
      r_len <= axi.arlen;
      r_cnt <= '0;
      r_burst <= axi.arburst;
      r_err <= ar_chk;
      r_id <= axi.arid;
      r_data <= ar_chk == OKAY ? mem[idx(axi.araddr)] : '0;
    end else if (r_hs && r_cnt != r_len) begin
      r_addr <= r_nxt;
      r_err <= r_nerr;
      r_cnt <= r_cnt + 8'd1;
      r_data <= r_nerr == OKAY ? mem[idx(r_nxt)] : '0;
    end
endmodule

// File: tb/tb_axi_slave_ram.sv
// tb_axi_slave_ram: randomized scoreboard bench for axi_slave_ram against a word-array reference model
module tb_axi_slave_ram;
  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef AXI_SLAVE_RAM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif
  typedef struct {logic [31:0] d; logic [1:0] resp; logic last; logic id;} rbeat_t;
  logic clk = 1'b0, rst = 1'b1;
  int errors = 0, checks = 0, rmode = 0;
  logic [31:0] mm [1024];
  rbeat_t rq [$];
  logic [2:0] bq [$];
  always #5 clk = ~clk;
  axi_slave_ram_if #(.AXI_ID_WIDTH(1), .AXI_ADDR_WIDTH(32)) axi ();
  axi_slave_ram #(.AXI_ID_WIDTH(1), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .MEM_WORDS_LOG2(10), .BASE_ADDR(BASE)) dut (
    .aclk(clk), .areset(rst), .axi(axi));

  task automatic check(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic fail(input string n);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", n);
  endtask

  function automatic bit in_w(input logic [31:0] a);
    return a >= BASE && a < BASE + 32'h1000;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [1:0] berr(input logic [2:0] s, input logic [1:0] b, input logic [7:0] l, input logic [31:0] a);
    if (s != 3'd2 || b == 2'd3 || (b == 2'd2 && !(WRAP_EN && (l == 1 || l == 3 || l == 7 || l == 15)))) return 2'b10;
    return in_w(a) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [31:0] baddr(input logic [31:0] a, input logic [1:0] b, input logic [7:0] l, input int i);
    logic [31:0] a0, span, bnd;
    a0 = a & ~32'h3;
    span = 32'(4 * (int'(l) + 1));
    bnd = a0 - a0 % span;
    return b == 2'd0 ? a0 : b == 2'd2 ? bnd + (a0 - bnd + 32'(4 * i)) % span : a0 + 32'(4 * i);
  endfunction

  task automatic hs(input int ch);
    bit r;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      r = ch == 0 ? axi.awready : ch == 1 ? axi.wready : axi.arready;
      @(posedge clk);
      #1;
      if (r) return;
    end
    fail("handshake_timeout");
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bst, input logic [2:0] sz,
                    input int lm, input logic [3:0] st, input logic [31:0] d0, input bit rnd, input bit gaps);
    logic [1:0] e;
    logic id;
    logic [31:0] ad, dv;
    logic [31:0] d [$];
    id = 1'($urandom_range(0, 1));
    e = berr(sz, bst, len, a);
    for (int i = 0; i <= int'(len); i++) begin
      dv = rnd ? $urandom : d0 + 32'(i);
      d.push_back(dv);
      ad = baddr(a, bst, len, i);
      if (e == 2'b00 && !in_w(ad)) e = 2'b11;
      if (e == 2'b00)
        for (int b = 0; b < 4; b++) if (st[b]) mm[widx(ad)][8*b +: 8] = dv[8*b +: 8];
    end
    bq.push_back({id, e != 2'b00 ? e : lm != 0 ? 2'b10 : 2'b00});
    axi.awid = id; axi.awaddr = a; axi.awlen = len; axi.awsize = sz; axi.awburst = bst; axi.awvalid = 1'b1;
    hs(0);
    axi.awvalid = 1'b0;
    check("wready_latency", axi.wready, 1);
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        axi.wvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      axi.wdata = d[i];
      axi.wstrb = st;
      axi.wlast = lm == 0 ? i == int'(len) : lm == 1 ? i == int'(len) - 1 : 1'b0;
      axi.wvalid = 1'b1;
      hs(1);
    end
    axi.wvalid = 1'b0;
    axi.wlast = 1'b0;
    for (int c = 0; c < 500 && bq.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    if (bq.size() != 0) begin
      fail("b_timeout");
      bq.delete();
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bst, input logic [2:0] sz);
    logic [1:0] e;
    logic id;
    logic [31:0] ad;
    id = 1'($urandom_range(0, 1));
    e = berr(sz, bst, len, a);
    for (int i = 0; i <= int'(len); i++) begin
      ad = baddr(a, bst, len, i);
      if (e == 2'b00 && !in_w(ad)) e = 2'b11;
      rq.push_back('{e == 2'b00 ? mm[widx(ad)] : 32'h0, e, i == int'(len), id});
    end
    axi.arid = id; axi.araddr = a; axi.arlen = len; axi.arsize = sz; axi.arburst = bst; axi.arvalid = 1'b1;
    hs(2);
    axi.arvalid = 1'b0;
    check("rvalid_latency", axi.rvalid, 1);
    for (int c = 0; c < 2000 && rq.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    if (rq.size() != 0) begin
      fail("r_timeout");
      rq.delete();
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    axi.rready = rmode == 0 ? 1'b1 : rmode == 1 ? ~axi.rready : 1'($urandom_range(0, 1));
    axi.bready = 1'($urandom_range(0, 1));
  end

  bit rs_v, bs_v, gap;
  logic [35:0] rs_s;
  logic [2:0] bs_s;
  rbeat_t p;
  always @(negedge clk)
    if (rst) begin
      rs_v = 0;
      bs_v = 0;
      gap = 0;
    end else begin
      if (gap) check("r_gap", axi.rvalid, 0);
      gap = 0;
      if (rs_v) check("r_stall", {axi.rvalid, axi.rid, axi.rresp, axi.rlast, axi.rdata}, {1'b1, rs_s});
      if (bs_v) check("b_stall", {axi.bvalid, axi.bid, axi.bresp}, {1'b1, bs_s});
      rs_v = axi.rvalid && !axi.rready;
      rs_s = {axi.rid, axi.rresp, axi.rlast, axi.rdata};
      bs_v = axi.bvalid && !axi.bready;
      bs_s = {axi.bid, axi.bresp};
      if (axi.bvalid && axi.bready) begin
        if (bq.size() == 0) fail("b_unexpected");
        else check("bresp", {axi.bid, axi.bresp}, bq.pop_front());
      end
      if (axi.rvalid && axi.rready) begin
        if (rq.size() == 0) fail("r_unexpected");
        else begin
          p = rq.pop_front();
          check("rdata", axi.rdata, p.d);
          check("rctl", {axi.rid, axi.rresp, axi.rlast}, {p.id, p.resp, p.last});
          gap = axi.rlast;
        end
      end
    end

  initial begin
    logic [31:0] a, dv;
    logic [7:0] len;
    logic [1:0] bst;
    logic [2:0] sz;
    int lm;
    axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0; axi.rready = 0; axi.bready = 0;
    axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0;
    axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0;
    axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid, axi.rlast}, 0);
    check("rst_data", {axi.rdata, axi.bresp, axi.rresp, axi.bid, axi.rid}, 0);
    rst = 0;
    @(negedge clk);
    check("awready_first_edge", {axi.awready, axi.arready}, 0);
    @(posedge clk);
    #1;
    check("awready_after_edge", {axi.awready, axi.arready}, 2'b11);
    for (int k = 0; k < 4; k++) wr(BASE + 32'(k * 1024), 8'd255, 2'd1, 3'd2, 0, 4'hF, 0, 1, 0);
    wr(BASE, 8'd31, 2'd1, 3'd2, 0, 4'hF, 32'h6434_3962, 0, 1);
    rd(BASE, 8'd31, 2'd1, 3'd2);
    wr(32'h9000_0000, 8'd31, 2'd1, 3'd2, 0, 4'hF, 0, 1, 0);
    rd(32'hE000_0000, 8'd7, 2'd1, 3'd2);
    rd(BASE, 8'd31, 2'd1, 3'd2);
    wr(BASE + 32'h40, 8'd0, 2'd1, 3'd2, 0, 4'hF, 32'hFFFF_FFFF, 0, 0);
    wr(BASE + 32'h40, 8'd0, 2'd1, 3'd2, 0, 4'b0011, 32'h1234_5678, 0, 0);
    rd(BASE + 32'h40, 8'd0, 2'd1, 3'd2);
    wr(BASE + 32'h8, 8'd3, 2'd2, 3'd2, 0, 4'hF, 32'hA, 0, 0);
    rd(BASE, 8'd3, 2'd1, 3'd2);
    rd(BASE + 32'h8, 8'd3, 2'd2, 3'd2);
    rmode = 1;
    rd(BASE + 32'h100, 8'd15, 2'd1, 3'd2);
    rmode = 0;
    wr(BASE + 32'h300, 8'd7, 2'd1, 3'd2, 1, 4'hF, 0, 1, 0);
    wr(BASE + 32'h300, 8'd7, 2'd1, 3'd2, 2, 4'hF, 0, 1, 0);
    wr(BASE + 32'hFF0, 8'd7, 2'd1, 3'd2, 0, 4'hF, 0, 1, 0);
    rd(BASE + 32'hFF0, 8'd7, 2'd1, 3'd2);
    wr(BASE, 8'd3, 2'd1, 3'd3, 0, 4'hF, 0, 1, 0);
    wr(BASE + 32'h80, 8'd3, 2'd0, 3'd2, 0, 4'hF, 0, 1, 0);
    rd(BASE + 32'h80, 8'd3, 2'd0, 3'd2);
    rd(BASE, 8'd2, 2'd3, 3'd2);
    for (int n = 0; n < 40; n++) begin
      a = $urandom_range(0, 9) == 0 ? $urandom : BASE + $urandom_range(0, 32'hFFF);
      bst = 2'($urandom_range(0, 3));
      len = bst == 2'd2 ? 8'((2 << $urandom_range(0, 3)) - 1) : 8'($urandom_range(0, 15));
      if (bst == 2'd2 && $urandom_range(0, 4) == 0) len = 8'd2;
      sz = $urandom_range(0, 7) == 0 ? 3'd1 : 3'd2;
      lm = len != 0 && $urandom_range(0, 5) == 0 ? int'($urandom_range(1, 2)) : 0;
      wr(a, len, bst, sz, lm, 4'($urandom_range(0, 15)), 0, 1, 1);
      rmode = 2;
      rd(a, len, bst, sz);
      rmode = 0;
    end
    axi.awid = 0; axi.awaddr = BASE + 32'h400; axi.awlen = 8'd31; axi.awsize = 3'd2; axi.awburst = 2'd1; axi.awvalid = 1;
    hs(0);
    axi.awvalid = 0;
    for (int i = 0; i < 5; i++) begin
      dv = $urandom;
      mm[256 + i] = dv;
      axi.wdata = dv; axi.wstrb = 4'hF; axi.wlast = 0; axi.wvalid = 1;
      hs(1);
    end
    axi.wdata = $urandom;
    axi.wvalid = 1;
    #2 rst = 1;
    #1 check("rst_async", {axi.wready, axi.bvalid, axi.rvalid, axi.awready, axi.arready}, 0);
    axi.wvalid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("awready_rerelease", axi.awready, 0);
    @(posedge clk);
    #1;
    check("awready_reup", axi.awready, 1);
    rd(BASE + 32'h400, 8'd31, 2'd1, 3'd2);
    wr(BASE + 32'h400, 8'd3, 2'd1, 3'd2, 0, 4'hF, 0, 1, 0);
    rd(BASE + 32'h400, 8'd3, 2'd1, 3'd2);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
